// File: rtl/boot_imem.sv
// boot_imem: reloadable instruction memory with byte-serial load port and optional registered fetch
module boot_imem #(
    parameter int          ADDR_W    = 8,
    parameter int          REG_OUT   = 0,
    parameter logic [31:0] OOR_WORD  = 32'h0000_0000,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr,
    output logic [31:0]       data,
    output logic              addr_err,
    input  logic              ld_start,
    input  logic [ADDR_W:0]   ld_len,
    input  logic [7:0]        ld_byte,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              cpu_hold
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t          state_q, state_d;
    logic [31:0]     mem_q [DEPTH];
    logic [ADDR_W:0] len_q, len_d, word_ptr_q, word_ptr_d, len_clamped;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [23:0]     asm_q, asm_d;
    logic            accept, word_end, last_word, wr_en;
    logic [31:0]     fetch;

    assign len_clamped = (ld_len > DEPTH_W) ? DEPTH_W : ld_len;
    assign accept      = ld_valid && ld_ready;
    assign word_end    = accept && byte_cnt_q == 2'd3;
    assign last_word   = word_ptr_q + ONE == len_q;
    assign wr_en       = word_end && !reset;
    assign addr_err    = |addr[1:0];
    assign fetch       = (|addr[31:ADDR_W+2]) ? OOR_WORD : mem_q[addr[ADDR_W+1:2]];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_ptr_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_ptr_q <= word_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[word_ptr_q[ADDR_W-1:0]] <= {asm_q, ld_byte};
    end

    always_comb begin
        len_d      = len_q;
        word_ptr_d = word_ptr_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        if (state_q == IDLE && ld_start) begin
            len_d      = len_clamped;
            word_ptr_d = '0;
            byte_cnt_d = '0;
        end
        if (accept) begin
            asm_d      = {asm_q[15:0], ld_byte};
            byte_cnt_d = byte_cnt_q + 2'd1;
            word_ptr_d = word_end ? word_ptr_q + ONE : word_ptr_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ld_start) state_d = (len_clamped == '0) ? DONE : LOAD;
            LOAD:    if (word_end && last_word) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ld_ready = state_q == LOAD;
        ld_done  = state_q == DONE;
        cpu_hold = state_q != IDLE;
    end

    if (REG_OUT != 0) begin : g_reg
        logic [31:0] data_q;
        always_ff @(posedge clk) begin
            if (reset) data_q <= '0;
            else data_q <= fetch;
        end
        assign data = data_q;
    end else begin : g_comb
        assign data = fetch;
    end
endmodule

// File: tb/tb_boot_imem.sv
// tb_boot_imem: randomized scoreboard bench for boot_imem, combinational and registered variants side by side
module tb_boot_imem;
    localparam logic [31:0] OOR = 32'hDEAD_BEEF;

    typedef struct {
        int          due;
        logic [31:0] exp;
        logic        err;
    } fe_t;

    logic        clk = 1'b0, reset = 1'b1;
    logic [31:0] addr = '0;
    logic        ld_start = 1'b0, ld_valid = 1'b0;
    logic [8:0]  ld_len = '0;
    logic [7:0]  ld_byte = '0;
    logic [31:0] data0, data1;
    logic        err0, err1, ready0, ready1, done0, done1, hold0, hold1;

    int          checks = 0, errors = 0, cyc = 0, phase = 0;
    logic [31:0] ref_mem [256];
    logic [7:0]  src [$];
    int          done_q [$];
    fe_t         q0 [$], q1 [$];

    boot_imem #(.ADDR_W(8), .REG_OUT(0), .OOR_WORD(OOR)) u_comb (
        .clk(clk), .reset(reset), .addr(addr), .data(data0), .addr_err(err0),
        .ld_start(ld_start), .ld_len(ld_len), .ld_byte(ld_byte), .ld_valid(ld_valid),
        .ld_ready(ready0), .ld_done(done0), .cpu_hold(hold0)
    );

    boot_imem #(.ADDR_W(8), .REG_OUT(1), .OOR_WORD(OOR)) u_reg (
        .clk(clk), .reset(reset), .addr(addr), .data(data1), .addr_err(err1),
        .ld_start(ld_start), .ld_len(ld_len), .ld_byte(ld_byte), .ld_valid(ld_valid),
        .ld_ready(ready1), .ld_done(done1), .cpu_hold(hold1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // monitor: handshake outputs every cycle, ld_done against scheduled pulses, fetches against queued words
    always @(negedge clk) begin
        if (!reset) begin
            logic exp_done;
            fe_t  e;
            exp_done = done_q.size() > 0 && done_q[0] == cyc;
            chk("cpu_hold_comb", 32'(hold0), 32'(phase != 0));
            chk("cpu_hold_reg", 32'(hold1), 32'(phase != 0));
            chk("ld_ready_comb", 32'(ready0), 32'(phase == 1));
            chk("ld_ready_reg", 32'(ready1), 32'(phase == 1));
            chk("ld_done_comb", 32'(done0), 32'(exp_done));
            chk("ld_done_reg", 32'(done1), 32'(exp_done));
            if (exp_done) void'(done_q.pop_front());
            while (q0.size() > 0 && q0[0].due <= cyc) begin
                e = q0.pop_front();
                chk("fetch_comb", data0, e.exp);
                chk("addr_err", 32'(err0), 32'(e.err));
            end
            while (q1.size() > 0 && q1[0].due <= cyc) begin
                e = q1.pop_front();
                chk("fetch_reg", data1, e.exp);
            end
        end
    end

    task automatic fetch_check(input logic [31:0] a);
        fe_t e;
        addr  = a;
        e.exp = (a[31:10] != 0) ? OOR : ref_mem[a[9:2]];
        e.err = a[1:0] != 2'b00;
        e.due = cyc;
        q0.push_back(e);
        e.due = cyc + 1;
        q1.push_back(e);
        @(posedge clk); #1;
    endtask

    // issues a load of len words, feeding nb bytes from src; watch>=0 fetches that word on its write edge
    task automatic do_load(input int len, input int nb, input bit gaps, input int watch);
        int          clamped, ptr;
        logic [31:0] w;
        fe_t         e;
        clamped  = (len > 256) ? 256 : len;
        ptr      = 0;
        w        = '0;
        ld_start = 1'b1;
        ld_len   = 9'(len);
        @(posedge clk); #1;
        ld_start = 1'b0;
        phase    = (clamped == 0) ? 2 : 1;
        if (clamped == 0) done_q.push_back(cyc);
        for (int i = 0; i < nb; i++) begin
            if (gaps) begin
                ld_valid = 1'b0;
                ld_start = 1'($urandom_range(0, 1));
                ld_len   = 9'($urandom);
                @(posedge clk); #1;
                ld_start = 1'b0;
            end
            ld_byte  = src.pop_front();
            ld_valid = 1'b1;
            w        = {w[23:0], ld_byte};
            if (i % 4 == 3 && i / 4 == watch) begin
                addr  = 32'(watch * 4);
                e.err = 1'b0;
                e.due = cyc + 1;
                e.exp = w;
                q0.push_back(e);
                e.exp = ref_mem[watch];
                q1.push_back(e);
            end
            @(posedge clk); #1;
            ld_valid = 1'b0;
            if (i % 4 == 3) begin
                ref_mem[ptr] = w;
                ptr++;
                if (ptr == clamped) begin
                    phase = 2;
                    done_q.push_back(cyc);
                end
            end
        end
        if (phase == 2) begin
            @(posedge clk); #1;
            phase = 0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] t2 [8] = '{8'h3C, 8'h08, 8'h40, 8'h00, 8'h20, 8'h09, 8'h07, 8'hFF};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ld_ready", 32'(ready0 | ready1), 32'd0);
        chk("reset_ld_done", 32'(done0 | done1), 32'd0);
        chk("reset_cpu_hold", 32'(hold0 | hold1), 32'd0);
        chk("reset_data_reg", data1, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (t2[i]) src.push_back(t2[i]);
        do_load(2, 8, 1'b0, -1);
        fetch_check(32'h4);
        fetch_check(32'h0);

        ld_valid = 1'b1;
        ld_byte  = 8'hAA;
        repeat (2) @(posedge clk);
        #1;
        ld_valid = 1'b0;

        foreach (t2[i]) src.push_back(t2[i]);
        do_load(2, 8, 1'b1, -1);
        fetch_check(32'h0);
        fetch_check(32'h4);

        repeat (1024) src.push_back(8'($urandom));
        do_load(300, 1024, 1'b0, 1);
        for (int i = 0; i < 20; i++) fetch_check(32'($urandom_range(0, 255)) << 2);
        fetch_check(32'h400);
        fetch_check(32'h3);
        fetch_check(32'h3FC);
        for (int i = 0; i < 20; i++) fetch_check($urandom);
        for (int i = 0; i < 10; i++) fetch_check(32'($urandom_range(0, 1023)));

        repeat (5) src.push_back(8'($urandom));
        do_load(2, 5, 1'b0, -1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        phase = 0;
        fetch_check(32'h0);
        fetch_check(32'h4);

        do_load(0, 0, 1'b0, -1);
        fetch_check(32'h8);

        repeat (3) @(posedge clk);
        #1;
        chk("pending_ld_done", 32'(done_q.size()), 32'd0);
        chk("pending_fetch", 32'(q0.size() + q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
